// File: rtl/opb_status_bank_simulink2ppc.sv
// OPB-mapped bank of N_CH status words (plain capture or sticky W1C) with a global freeze bit.
// Optional per-channel event counters are built when STATUS_EVT_CNT_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for a select that hits the window
// S_ACK  | single acknowledge cycle; read data driven, write commits at its end
// S_HOLD | transfer done, waiting for the master to drop select
module opb_status_bank_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h01089100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010891FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          N_CH         = 4,
  parameter logic [15:0] STICKY_MASK  = 16'h0000
) (
  input  logic                 OPB_Clk,
  input  logic                 OPB_Rst,
  input  logic [0:31]          OPB_ABus,
  input  logic [0:3]           OPB_BE,
  input  logic [0:31]          OPB_DBus,
  input  logic                 OPB_RNW,
  input  logic                 OPB_select,
  input  logic                 OPB_seqAddr,
  output logic [0:31]          Sl_DBus,
  output logic                 Sl_xferAck,
  output logic                 Sl_errAck,
  output logic                 Sl_retry,
  output logic                 Sl_toutSup,
  input  logic [N_CH*32-1:0]   user_data_in,
  input  logic [N_CH-1:0]      user_valid
);

  localparam logic [5:0] CTRL_WORD = 6'd32;
  localparam int         CNT_WORD0 = 16;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;
  state_t state, next_state;

  logic [31:0]     abus, wdata, offset, be_mask, clr_mask, rd_mux, dbus_q;
  logic [3:0]      be_v;
  logic [5:0]      word, word_q;
  logic            hit, ld, wr_commit, rnw_q, xfer_ack_q, freeze;
  logic [N_CH-1:0] capture;
  logic [31:0]     ch_reg [N_CH];
  logic            unused_ok;

  assign abus     = OPB_ABus;
  assign wdata    = OPB_DBus;
  assign be_v     = OPB_BE;
  assign offset   = abus - C_BASEADDR;
  assign word     = offset[7:2];
  assign hit      = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  // be_v[3] is OPB_BE[0], which covers the most significant byte
  assign be_mask  = {{8{be_v[3]}}, {8{be_v[2]}}, {8{be_v[1]}}, {8{be_v[0]}}};
  assign clr_mask = wdata & be_mask;
  assign capture  = user_valid & {N_CH{~freeze}};

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = xfer_ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_ok = &{1'b0, OPB_seqAddr, offset[31:8], offset[1:0],
                       (C_OPB_AWIDTH == 32), (C_OPB_DWIDTH == 32)};

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    ld         = 1'b0;
    wr_commit  = 1'b0;
    case (state)
      S_IDLE: if (hit) begin
        next_state = S_ACK;
        ld         = 1'b1;
      end
      S_ACK: begin
        next_state = S_HOLD;
        wr_commit  = ~rnw_q;
      end
      S_HOLD: if (!OPB_select) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

`ifdef STATUS_EVT_CNT_EN
  logic [15:0] evt_cnt [N_CH];
  logic [15:0] evt_nxt [N_CH];

  // a clear and a pulse in the same cycle leave the count at 1
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      evt_nxt[i] = (wr_commit && word_q == 6'(CNT_WORD0 + i)) ? 16'h0000 : evt_cnt[i];
      if (capture[i] && evt_nxt[i] != 16'hFFFF) evt_nxt[i] = evt_nxt[i] + 16'd1;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (OPB_Rst) evt_cnt[i] <= 16'h0000;
      else         evt_cnt[i] <= evt_nxt[i];
    end
  end
`endif

  always_comb begin
    rd_mux = 32'h0;
    for (int i = 0; i < N_CH; i++) begin
      if (word == 6'(i)) rd_mux = ch_reg[i];
`ifdef STATUS_EVT_CNT_EN
      if (word == 6'(CNT_WORD0 + i)) rd_mux = {16'h0000, evt_cnt[i]};
`endif
    end
    if (word == CTRL_WORD) rd_mux = {31'h0, freeze};
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      rnw_q      <= 1'b0;
      word_q     <= 6'h0;
      xfer_ack_q <= 1'b0;
      dbus_q     <= 32'h0;
    end else begin
      xfer_ack_q <= ld;
      dbus_q     <= (ld && OPB_RNW) ? rd_mux : 32'h0;
      if (ld) begin
        rnw_q  <= OPB_RNW;
        word_q <= word;
      end
    end
  end

  // sticky: set from a same-cycle capture takes priority over the W1C clear
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int i = 0; i < N_CH; i++) ch_reg[i] <= 32'h0;
      freeze <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (STICKY_MASK[i])
          ch_reg[i] <= (ch_reg[i] & ~((wr_commit && word_q == 6'(i)) ? clr_mask : 32'h0))
                       | (capture[i] ? user_data_in[32*i +: 32] : 32'h0);
        else if (capture[i])
          ch_reg[i] <= user_data_in[32*i +: 32];
      end
      if (wr_commit && word_q == CTRL_WORD && be_v[0]) freeze <= wdata[0];
    end
  end

endmodule
